// File: rtl/fuel_dispense_bcd_ctrl.sv
// Fuel pump dispense controller: counts flow pulses into BCD volume/cost totals
// and scans the selected total one digit at a time onto a one-hot digit enable.
module fuel_dispense_bcd_ctrl #(
  parameter int unsigned PULSES_PER_UNIT = 10,
  parameter int unsigned SCAN_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        flow_pulse,
  input  logic [7:0]  price_bcd,
  input  logic        disp_sel,
  output logic        valve_open,
  output logic        limit_hit,
  output logic [15:0] volume_bcd,
  output logic [15:0] cost_bcd,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SCAN_W = 16;
  localparam int unsigned TOT_W  = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [TOT_W-1:0]  volume_q, volume_d;
  logic [TOT_W-1:0]  cost_q, cost_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [7:0]        price_q, price_d;
  logic              limit_q, limit_d;
  logic              valve_q, valve_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [3:0]        digit_en_q, digit_en_d;
  logic [3:0]        bcd_out_q, bcd_out_d;

  logic [TOT_W:0]    vol_sum;
  logic [TOT_W:0]    cost_sum;
  logic              unit_done;
  logic              overflow;
  logic              scan_wrap;
  logic [TOT_W-1:0]  sel_total;

  // Four-digit BCD add; bit 16 of the result is the decimal carry out of digit 3.
  function automatic logic [16:0] bcd_add16(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  assign vol_sum   = bcd_add16(volume_q, 16'h0001);
  assign cost_sum  = bcd_add16(cost_q, {8'h00, price_q});
  assign unit_done = flow_pulse && (pcnt_q == CNT_W'(PULSES_PER_UNIT - 1));
  assign overflow  = (volume_q == 16'h9999) || cost_sum[TOT_W];

  // Transaction FSM and totals
  always_comb begin
    state_d  = state_q;
    volume_d = volume_q;
    cost_d   = cost_q;
    pcnt_d   = pcnt_q;
    price_d  = price_q;
    limit_d  = limit_q;
    case (state_q)
      ST_IDLE: begin
        volume_d = '0;
        cost_d   = '0;
        pcnt_d   = '0;
        if (start && !clr) begin
          state_d = ST_DISPENSE;
          price_d = price_bcd;
          limit_d = 1'b0;
        end
      end
      ST_DISPENSE: begin
        if (clr) begin
          state_d  = ST_IDLE;
          volume_d = '0;
          cost_d   = '0;
          pcnt_d   = '0;
          limit_d  = 1'b0;
        end else begin
          if (unit_done) begin
            pcnt_d = '0;
            if (overflow) begin
              limit_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              volume_d = vol_sum[TOT_W-1:0];
              cost_d   = cost_sum[TOT_W-1:0];
            end
          end else if (flow_pulse) begin
            pcnt_d = pcnt_q + 8'd1;
          end
          if (stop) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (clr) begin
          state_d  = ST_IDLE;
          volume_d = '0;
          cost_d   = '0;
          pcnt_d   = '0;
          limit_d  = 1'b0;
        end else if (start) begin
          state_d  = ST_DISPENSE;
          price_d  = price_bcd;
          volume_d = '0;
          cost_d   = '0;
          pcnt_d   = '0;
          limit_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        volume_d = '0;
        cost_d   = '0;
        pcnt_d   = '0;
        limit_d  = 1'b0;
      end
    endcase
  end

  assign valve_d = (state_d == ST_DISPENSE);

  // Digit scanner; bcd_out tracks next-cycle totals so it matches digit_en after every edge
  assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
  assign sel_total = disp_sel ? cost_d : volume_d;

  always_comb begin
    scan_d     = scan_wrap ? '0 : scan_q + 16'd1;
    digit_en_d = scan_wrap ? {digit_en_q[2:0], digit_en_q[3]} : digit_en_q;
    bcd_out_d  = 4'd0;
    case (digit_en_d)
      4'b0001: bcd_out_d = sel_total[3:0];
      4'b0010: bcd_out_d = sel_total[7:4];
      4'b0100: bcd_out_d = sel_total[11:8];
      4'b1000: bcd_out_d = sel_total[15:12];
      default: bcd_out_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      volume_q   <= '0;
      cost_q     <= '0;
      pcnt_q     <= '0;
      price_q    <= '0;
      limit_q    <= 1'b0;
      valve_q    <= 1'b0;
      scan_q     <= '0;
      digit_en_q <= 4'b0001;
      bcd_out_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      volume_q   <= volume_d;
      cost_q     <= cost_d;
      pcnt_q     <= pcnt_d;
      price_q    <= price_d;
      limit_q    <= limit_d;
      valve_q    <= valve_d;
      scan_q     <= scan_d;
      digit_en_q <= digit_en_d;
      bcd_out_q  <= bcd_out_d;
    end
  end

  assign valve_open = valve_q;
  assign limit_hit  = limit_q;
  assign volume_bcd = volume_q;
  assign cost_bcd   = cost_q;
  assign bcd_out    = bcd_out_q;
  assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_fuel_dispense_bcd_ctrl.sv
// Directed bench for fuel_dispense_bcd_ctrl: a vector table for the main
// transaction flow plus hand sequences for overflow, scanning and reset.
module tb_fuel_dispense_bcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, clr, flow, disp_sel;
  logic [7:0]  price;
  logic        valve, limit;
  logic [15:0] vol, cost;
  logic [3:0]  bcd, den;

  logic        start1, flow1;
  logic [7:0]  price1;
  logic        valve1, limit1;
  logic [15:0] vol1, cost1;
  logic [3:0]  bcd1, den1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fuel_dispense_bcd_ctrl #(.PULSES_PER_UNIT(10), .SCAN_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
    .flow_pulse(flow), .price_bcd(price), .disp_sel(disp_sel),
    .valve_open(valve), .limit_hit(limit), .volume_bcd(vol), .cost_bcd(cost),
    .bcd_out(bcd), .digit_en(den)
  );

  fuel_dispense_bcd_ctrl #(.PULSES_PER_UNIT(1), .SCAN_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(1'b0), .clr(1'b0),
    .flow_pulse(flow1), .price_bcd(price1), .disp_sel(1'b0),
    .valve_open(valve1), .limit_hit(limit1), .volume_bcd(vol1), .cost_bcd(cost1),
    .bcd_out(bcd1), .digit_en(den1)
  );

  typedef struct {
    int          reps;
    logic [3:0]  ctl;    // {start, stop, clr, flow}
    logic [7:0]  price;
    logic [1:0]  vl;     // {valve_open, limit_hit}
    logic [15:0] vol;
    logic [15:0] cost;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic [3:0] ctl, input logic [7:0] p);
    @(negedge clk);
    {start, stop, clr, flow} = ctl;
    price = p;
    @(posedge clk);
    #1;
    {start, stop, clr, flow} = 4'b0000;
  endtask

  task automatic step1(input logic s, input logic f, input logic [7:0] p);
    @(negedge clk);
    start1 = s;
    flow1  = f;
    price1 = p;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    flow1  = 1'b0;
  endtask

  // Sync to the 1000 -> 0001 rotation, then check 16 cycles of scan output
  task automatic scan_check(input string name, input logic [15:0] tot);
    logic [3:0] prev;
    logic [3:0] e_den;
    logic [3:0] e_bcd;
    bit         found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      prev = den;
      @(posedge clk);
      #1;
      if (prev == 4'b1000 && den == 4'b0001) found = 1'b1;
    end
    chk({name, "_sync"}, 32'(found), 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      e_den = 4'(1 << (k / 4));
      e_bcd = 4'(tot >> (4 * (k / 4)));
      chk($sformatf("%s_den%0d", name, k), 32'(den), 32'(e_den));
      chk($sformatf("%s_bcd%0d", name, k), 32'(bcd), 32'(e_bcd));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {start, stop, clr, flow} = 4'b0000;
    price = 8'h00;
    disp_sel = 1'b0;
    start1 = 1'b0;
    flow1 = 1'b0;
    price1 = 8'h00;

    tbl.push_back('{1,  4'b1000, 8'h25, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{29, 4'b0001, 8'h00, 2'b10, 16'h0002, 16'h0050});
    tbl.push_back('{1,  4'b0101, 8'h00, 2'b00, 16'h0003, 16'h0075});
    tbl.push_back('{5,  4'b0001, 8'h00, 2'b00, 16'h0003, 16'h0075});
    tbl.push_back('{1,  4'b1000, 8'h99, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b10, 16'h0001, 16'h0099});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b10, 16'h0002, 16'h0198});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b10, 16'h0003, 16'h0297});
    tbl.push_back('{90, 4'b0001, 8'h00, 2'b10, 16'h0012, 16'h1188});
    tbl.push_back('{1,  4'b0111, 8'h00, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b1000, 8'h00, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{20, 4'b0001, 8'h00, 2'b10, 16'h0002, 16'h0000});
    tbl.push_back('{9,  4'b0001, 8'h00, 2'b10, 16'h0002, 16'h0000});
    tbl.push_back('{1,  4'b0101, 8'h00, 2'b00, 16'h0003, 16'h0000});
    tbl.push_back('{1,  4'b1000, 8'h25, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b1010, 8'h25, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b1000, 8'h25, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b0100, 8'h00, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b1010, 8'h25, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{1,  4'b1000, 8'h25, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b10, 16'h0001, 16'h0025});
    tbl.push_back('{1,  4'b1000, 8'h99, 2'b10, 16'h0001, 16'h0025});
    tbl.push_back('{10, 4'b0001, 8'h00, 2'b10, 16'h0002, 16'h0050});

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valve", 32'(valve), 32'd0);
    chk("rst_limit", 32'(limit), 32'd0);
    chk("rst_vol",   32'(vol),   32'h0);
    chk("rst_cost",  32'(cost),  32'h0);
    chk("rst_den",   32'(den),   32'b0001);
    chk("rst_bcd",   32'(bcd),   32'd0);
    chk("rst1_vol",  32'(vol1),  32'h0);
    chk("rst1_den",  32'(den1),  32'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].ctl, tbl[i].price);
      chk($sformatf("v%0d_valve", i), 32'(valve), 32'(tbl[i].vl[1]));
      chk($sformatf("v%0d_limit", i), 32'(limit), 32'(tbl[i].vl[0]));
      chk($sformatf("v%0d_vol", i),   32'(vol),   32'(tbl[i].vol));
      chk($sformatf("v%0d_cost", i),  32'(cost),  32'(tbl[i].cost));
    end

    // Overflow with one pulse per unit at price 99
    step1(1'b1, 1'b0, 8'h99);
    chk("ovf_start_valve", 32'(valve1), 32'd1);
    for (int i = 0; i < 101; i++) step1(1'b0, 1'b1, 8'h00);
    chk("ovf101_vol",   32'(vol1),   32'h0101);
    chk("ovf101_cost",  32'(cost1),  32'h9999);
    chk("ovf101_limit", 32'(limit1), 32'd0);
    chk("ovf101_valve", 32'(valve1), 32'd1);
    step1(1'b0, 1'b1, 8'h00);
    chk("ovf102_vol",   32'(vol1),   32'h0101);
    chk("ovf102_cost",  32'(cost1),  32'h9999);
    chk("ovf102_limit", 32'(limit1), 32'd1);
    chk("ovf102_valve", 32'(valve1), 32'd0);
    step1(1'b0, 1'b1, 8'h00);
    chk("ovf_done_vol",   32'(vol1),   32'h0101);
    chk("ovf_done_limit", 32'(limit1), 32'd1);
    step1(1'b1, 1'b0, 8'h25);
    chk("ovf_restart_limit", 32'(limit1), 32'd0);
    chk("ovf_restart_cost",  32'(cost1),  32'h0);
    chk("ovf_restart_valve", 32'(valve1), 32'd1);

    // Build volume 0003 / cost 0075 in DONE, then scan both totals
    step(4'b0010, 8'h00);
    step(4'b1000, 8'h25);
    for (int i = 0; i < 29; i++) step(4'b0001, 8'h00);
    step(4'b0101, 8'h00);
    chk("scn_vol",   32'(vol),   32'h0003);
    chk("scn_cost",  32'(cost),  32'h0075);
    chk("scn_valve", 32'(valve), 32'd0);
    @(negedge clk);
    disp_sel = 1'b1;
    scan_check("scan_cost", 16'h0075);
    @(negedge clk);
    disp_sel = 1'b0;
    @(posedge clk);
    #1;
    chk("sel_switch_bcd", 32'(bcd), 32'(4'(16'h0003 >> (4 * (den == 4'b0010 ? 1 : den == 4'b0100 ? 2 : den == 4'b1000 ? 3 : 0)))));
    scan_check("scan_vol", 16'h0003);

    // Synchronous reset mid-dispense, then clr without start
    step(4'b1000, 8'h25);
    for (int i = 0; i < 20; i++) step(4'b0001, 8'h00);
    chk("mid_vol", 32'(vol), 32'h0002);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_vol",   32'(vol),   32'h0);
    chk("mrst_cost",  32'(cost),  32'h0);
    chk("mrst_valve", 32'(valve), 32'd0);
    chk("mrst_limit", 32'(limit), 32'd0);
    chk("mrst_den",   32'(den),   32'b0001);
    chk("mrst_bcd",   32'(bcd),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0010, 8'h00);
    chk("clr_idle_vol",   32'(vol),   32'h0);
    chk("clr_idle_valve", 32'(valve), 32'd0);
    for (int i = 0; i < 10; i++) step(4'b0001, 8'h00);
    chk("idle_flow_vol",   32'(vol),   32'h0);
    chk("idle_flow_cost",  32'(cost),  32'h0);
    chk("idle_flow_valve", 32'(valve), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
